pwm_regs_mc: RTL and testbench
==============================

// Module: pwm_regs_mc
// PURPOSE
//  Multi-channel, parametrised successor to the single-channel PWM register bank; sits between the SPI slave
//  and N_CH PWM counter/compare channels. Adds per-channel double-buffered PERIOD/COMPAREx (shadow->active on
//  counter wrap), sticky W1C overflow status, a keyed config lock and a force-load. Keeps toggle-based SPI writes.
// PARAMETERS
//  N_CH  4  channel count, 1..7 (requires 8+8*N_CH <= 2**AW and N_CH <= DW)
//  DW    8  register/data width
//  AW    6  address width
// PORTS
//  clk          in   1        system clock, all logic on rising edge
//  rst          in   1        synchronous, active-high reset
//  wr_toggle    in   1        SPI write request; every level change = one write (async domain)
//  wr_addr      in   AW       write address, stable from toggle until write completes
//  wr_data      in   DW       write data, same stability rule
//  rd_addr      in   AW       read address
//  rd_data      out  DW       combinational read data
//  load_evt     in   N_CH     per-channel counter-wrap pulse (shadow->active trigger)
//  ovf_evt      in   N_CH     per-channel overflow pulse (sets sticky status)
//  counter_val  in   N_CH*DW  live counter values, ch c at [c*DW +: DW]
//  period       out  N_CH*DW  active period per channel
//  compare1     out  N_CH*DW  active compare1 per channel
//  compare2     out  N_CH*DW  active compare2 per channel
//  prescale     out  N_CH*DW  prescale per channel (not buffered)
//  counter_en   out  N_CH     per-channel count enable
//  upnotdown    out  N_CH     per-channel direction, 1=up
//  pwm_en       out  N_CH     per-channel output enable
//  functions    out  N_CH*2   per-channel mode
//  soft_reset   out  N_CH     one-cycle per-channel counter reset pulse
//  irq          out  1        OR of (status & irq_mask)
// BEHAVIOUR
//  Reset (rst=1 at edge): all outputs/regs 0 except upnotdown=all 1; shadow_en=0, lock=0, status=0, mask=0.
//  Write sync: wr_toggle -> q1 -> q2 flops; wr_event = q2 ^ seen; seen<=q2 on event. Register updates on 3rd
//   rising edge after toggle change; exactly one write per toggle change. Reset mid-sync discards pending write.
//  Global map: 0x00 GCTRL [0]=shadow_en RW, [1]=lock RO; 0x01 LOCK key (W/O, reads 0): 0x5A sets lock,
//   0xA5 clears, others ignored; 0x02 STATUS W1C sticky ovf[N_CH-1:0]; 0x03 IRQ_MASK RW;
//   0x04 FORCE_LOAD W/O: bit c copies shadow->active for ch c; 0x05 ID RO = N_CH; 0x06-0x07 read 0.
//  Channel c base B=0x08+8*c: B+0 PERIOD, B+1 COMPARE1, B+2 COMPARE2, B+3 PRESCALE,
//   B+4 CTRL {functions[4:3], pwm_en[2], upnotdown[1], counter_en[0]}, B+5 COUNTER_RESET W/O (bit0=1 ->
//   soft_reset[c] high exactly one cycle after write edge), B+6 COUNTER_VAL RO, B+7 reads 0.
//  Unmapped/beyond-N_CH addresses: writes ignored, reads 0. Unused high bits read 0.
//  Shadowing: PERIOD/COMPARE1/COMPARE2 writes always land in shadow; reads return shadow.
//   shadow_en=0: active follows shadow on the same write edge. shadow_en=1: active <= shadow on edge where
//   load_evt[c]=1 or FORCE_LOAD bit c written. Write + load same edge: active takes OLD shadow, new
//   value waits for next load. shadow_en 1->0 copies all shadows to active on that edge.
//  Lock=1: writes to GCTRL, IRQ_MASK, FORCE_LOAD and all channel config (B+0..B+4) ignored; LOCK key,
//   STATUS W1C and COUNTER_RESET still accepted. Only 0xA5 or rst clears lock.
//  Status: bit c set on ovf_evt[c]; W1C clears; set and clear same edge -> set wins.
//  irq registered: irq = |(status & mask), one cycle after status/mask change.
// TESTING
//  rst; read all addrs -> zeros except CTRL bit1=1 per ch, ID=4; irq=0.
//  shadow_en=0, write PERIOD ch2=0x40 -> period[2] = 0x40 on 3rd clk after toggle, other ch unchanged.
//  shadow_en=1, write COMPARE1 ch0=0x33 -> active stays 0 until load_evt[0]; load coincident with 2nd
//   write 0x44 -> active=0x33, next load -> 0x44.
//  ovf_evt[1] pulse, mask=0x02 -> status=0x02, irq=1; W1C 0x02 same edge as new ovf -> status stays 0x02.
//  LOCK 0x5A, write PERIOD ch0=0xFF -> ignored, reads old; COUNTER_RESET ch3=1 -> soft_reset[3] 1-cycle
//   pulse; LOCK 0xA5 then PERIOD write -> accepted.
//  Toggle wr_toggle then assert rst before 3rd edge -> no register change; 2 back-to-back toggles 4 clks
//   apart -> exactly 2 writes.

Source files
------------

// File: rtl/pwm_regs_mc.sv
// rtl/pwm_regs_mc.sv - multi-channel PWM register bank with shadowed period/compare, W1C status and config lock
// Purpose: register file between a toggle-handshake SPI slave and N_CH PWM counter/compare channels.
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   wr_toggle/wr_addr/wr_data write request (one write per level change) with address and data
//   rd_addr -> rd_data        combinational register read
//   load_evt, ovf_evt         per-channel counter wrap / overflow pulses
//   counter_val               live counter values, readable through COUNTER_VAL
//   period, compare1/2        active (post-shadow) timing values per channel
//   prescale, counter_en, upnotdown, pwm_en, functions   per-channel configuration
//   soft_reset                one-cycle per-channel counter reset pulse
//   irq                       registered OR of masked sticky status
module pwm_regs_mc #(
  parameter int N_CH = 4,
  parameter int DW   = 8,
  parameter int AW   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_toggle,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_data,
  input  logic [AW-1:0]        rd_addr,
  output logic [DW-1:0]        rd_data,
  input  logic [N_CH-1:0]      load_evt,
  input  logic [N_CH-1:0]      ovf_evt,
  input  logic [N_CH*DW-1:0]   counter_val,
  output logic [N_CH*DW-1:0]   period,
  output logic [N_CH*DW-1:0]   compare1,
  output logic [N_CH*DW-1:0]   compare2,
  output logic [N_CH*DW-1:0]   prescale,
  output logic [N_CH-1:0]      counter_en,
  output logic [N_CH-1:0]      upnotdown,
  output logic [N_CH-1:0]      pwm_en,
  output logic [N_CH*2-1:0]    functions,
  output logic [N_CH-1:0]      soft_reset,
  output logic                 irq
);

  localparam logic [DW-1:0] KEY_LOCK   = DW'(8'h5A);
  localparam logic [DW-1:0] KEY_UNLOCK = DW'(8'hA5);
  // CTRL = {functions[1:0], pwm_en, upnotdown, counter_en}; counters count up out of reset
  localparam logic [4:0]    CTRL_RST   = 5'b00010;

  logic q1_q, q1_d, q2_q, q2_d, seen_q, seen_d;
  logic wr_fire;
  logic shadow_en_q, shadow_en_d, lock_q, lock_d;
  logic irq_q, irq_d;
  logic se_fall;
  logic [N_CH-1:0] status_q, status_d, mask_q, mask_d, soft_q, soft_d;
  logic [N_CH-1:0] force_ld, w1c;

  logic [DW-1:0] per_sh_q [N_CH];
  logic [DW-1:0] per_sh_d [N_CH];
  logic [DW-1:0] per_act_q[N_CH];
  logic [DW-1:0] per_act_d[N_CH];
  logic [DW-1:0] c1_sh_q  [N_CH];
  logic [DW-1:0] c1_sh_d  [N_CH];
  logic [DW-1:0] c1_act_q [N_CH];
  logic [DW-1:0] c1_act_d [N_CH];
  logic [DW-1:0] c2_sh_q  [N_CH];
  logic [DW-1:0] c2_sh_d  [N_CH];
  logic [DW-1:0] c2_act_q [N_CH];
  logic [DW-1:0] c2_act_d [N_CH];
  logic [DW-1:0] pre_q    [N_CH];
  logic [DW-1:0] pre_d    [N_CH];
  logic [4:0]    ctrl_q   [N_CH];
  logic [4:0]    ctrl_d   [N_CH];

  // Two-flop synchronizer on the toggle; a write fires while q2 differs from the last seen level.
  assign wr_fire = q2_q ^ seen_q;

  always_comb begin
    q1_d        = wr_toggle;
    q2_d        = q1_q;
    seen_d      = wr_fire ? q2_q : seen_q;
    shadow_en_d = shadow_en_q;
    lock_d      = lock_q;
    mask_d      = mask_q;
    force_ld    = '0;
    w1c         = '0;
    soft_d      = '0;
    se_fall     = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      per_sh_d[c]  = per_sh_q[c];
      per_act_d[c] = per_act_q[c];
      c1_sh_d[c]   = c1_sh_q[c];
      c1_act_d[c]  = c1_act_q[c];
      c2_sh_d[c]   = c2_sh_q[c];
      c2_act_d[c]  = c2_act_q[c];
      pre_d[c]     = pre_q[c];
      ctrl_d[c]    = ctrl_q[c];
    end

    if (wr_fire) begin
      if (wr_addr[AW-1:3] == '0) begin
        case (wr_addr[2:0])
          3'd0: if (!lock_q) begin
            shadow_en_d = wr_data[0];
            se_fall     = shadow_en_q & ~wr_data[0];
          end
          3'd1: begin
            if (wr_data == KEY_LOCK)        lock_d = 1'b1;
            else if (wr_data == KEY_UNLOCK) lock_d = 1'b0;
          end
          3'd2: w1c = wr_data[N_CH-1:0];
          3'd3: if (!lock_q) mask_d = wr_data[N_CH-1:0];
          3'd4: if (!lock_q) force_ld = wr_data[N_CH-1:0];
          default: ;
        endcase
      end
      for (int c = 0; c < N_CH; c++) begin
        if (wr_addr[AW-1:3] == (AW-3)'(c + 1)) begin
          case (wr_addr[2:0])
            3'd0: if (!lock_q) per_sh_d[c] = wr_data;
            3'd1: if (!lock_q) c1_sh_d[c]  = wr_data;
            3'd2: if (!lock_q) c2_sh_d[c]  = wr_data;
            3'd3: if (!lock_q) pre_d[c]    = wr_data;
            3'd4: if (!lock_q) ctrl_d[c]   = wr_data[4:0];
            3'd5: soft_d[c] = wr_data[0];
            default: ;
          endcase
        end
      end
    end

    // Set beats clear when an overflow and a W1C hit the same edge.
    status_d = (status_q & ~w1c) | ovf_evt;
    irq_d    = |(status_q & mask_q);

    // Unbuffered mode (and the edge that leaves buffered mode) passes the new shadow straight through;
    // buffered loads take the pre-edge shadow so a coincident write waits for the next load.
    for (int c = 0; c < N_CH; c++) begin
      if (!shadow_en_q || se_fall) begin
        per_act_d[c] = per_sh_d[c];
        c1_act_d[c]  = c1_sh_d[c];
        c2_act_d[c]  = c2_sh_d[c];
      end else if (load_evt[c] || force_ld[c]) begin
        per_act_d[c] = per_sh_q[c];
        c1_act_d[c]  = c1_sh_q[c];
        c2_act_d[c]  = c2_sh_q[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchronizer keeps running and seen tracks q2, so a toggle caught mid-sync is swallowed.
      q1_q        <= q1_d;
      q2_q        <= q2_d;
      seen_q      <= q2_d;
      shadow_en_q <= 1'b0;
      lock_q      <= 1'b0;
      irq_q       <= 1'b0;
      status_q    <= '0;
      mask_q      <= '0;
      soft_q      <= '0;
      for (int c = 0; c < N_CH; c++) begin
        per_sh_q[c]  <= '0;
        per_act_q[c] <= '0;
        c1_sh_q[c]   <= '0;
        c1_act_q[c]  <= '0;
        c2_sh_q[c]   <= '0;
        c2_act_q[c]  <= '0;
        pre_q[c]     <= '0;
        ctrl_q[c]    <= CTRL_RST;
      end
    end else begin
      q1_q        <= q1_d;
      q2_q        <= q2_d;
      seen_q      <= seen_d;
      shadow_en_q <= shadow_en_d;
      lock_q      <= lock_d;
      irq_q       <= irq_d;
      status_q    <= status_d;
      mask_q      <= mask_d;
      soft_q      <= soft_d;
      for (int c = 0; c < N_CH; c++) begin
        per_sh_q[c]  <= per_sh_d[c];
        per_act_q[c] <= per_act_d[c];
        c1_sh_q[c]   <= c1_sh_d[c];
        c1_act_q[c]  <= c1_act_d[c];
        c2_sh_q[c]   <= c2_sh_d[c];
        c2_act_q[c]  <= c2_act_d[c];
        pre_q[c]     <= pre_d[c];
        ctrl_q[c]    <= ctrl_d[c];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_addr[AW-1:3] == '0) begin
      case (rd_addr[2:0])
        3'd0: rd_data = DW'({lock_q, shadow_en_q});
        3'd2: rd_data = DW'(status_q);
        3'd3: rd_data = DW'(mask_q);
        3'd5: rd_data = DW'(N_CH);
        default: ;
      endcase
    end
    for (int c = 0; c < N_CH; c++) begin
      if (rd_addr[AW-1:3] == (AW-3)'(c + 1)) begin
        case (rd_addr[2:0])
          3'd0: rd_data = per_sh_q[c];
          3'd1: rd_data = c1_sh_q[c];
          3'd2: rd_data = c2_sh_q[c];
          3'd3: rd_data = pre_q[c];
          3'd4: rd_data = DW'(ctrl_q[c]);
          3'd6: rd_data = counter_val[c*DW +: DW];
          default: ;
        endcase
      end
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_out
    assign period[c*DW +: DW]   = per_act_q[c];
    assign compare1[c*DW +: DW] = c1_act_q[c];
    assign compare2[c*DW +: DW] = c2_act_q[c];
    assign prescale[c*DW +: DW] = pre_q[c];
    assign counter_en[c]        = ctrl_q[c][0];
    assign upnotdown[c]         = ctrl_q[c][1];
    assign pwm_en[c]            = ctrl_q[c][2];
    assign functions[c*2 +: 2]  = ctrl_q[c][4:3];
  end

  assign soft_reset = soft_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_pwm_regs_mc.sv
// tb/tb_pwm_regs_mc.sv - randomized self-checking bench for pwm_regs_mc against a register-level model
module tb_pwm_regs_mc;
  localparam int N = 4, DW = 8, AW = 6;
  localparam int ALLM = (1 << N) - 1;

  logic clk = 1'b0, rst = 1'b1, wr_toggle = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0, rd_data;
  logic [N-1:0] load_evt = '0, ovf_evt = '0;
  logic [N*DW-1:0] counter_val = '0;
  logic [N*DW-1:0] period, compare1, compare2, prescale;
  logic [N-1:0] counter_en, upnotdown, pwm_en, soft_reset;
  logic [2*N-1:0] functions;
  logic irq;

  pwm_regs_mc #(.N_CH(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_toggle(wr_toggle), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .load_evt(load_evt), .ovf_evt(ovf_evt),
    .counter_val(counter_val), .period(period), .compare1(compare1), .compare2(compare2),
    .prescale(prescale), .counter_en(counter_en), .upnotdown(upnotdown), .pwm_en(pwm_en),
    .functions(functions), .soft_reset(soft_reset), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int pend = 0, pulse_cnt = 0;
  bit rnd_mode = 0;

  // Model: [c][0]=PERIOD [c][1]=COMPARE1 [c][2]=COMPARE2
  int m_sh[N][3], m_act[N][3], m_pre[N], m_ctrl[N];
  int m_status, m_mask;
  bit m_se, m_lock, m_irq;
  bit [N-1:0] m_soft;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      for (int k = 0; k < 3; k++) begin m_sh[c][k] = 0; m_act[c][k] = 0; end
      m_pre[c] = 0; m_ctrl[c] = 2;
    end
    m_status = 0; m_mask = 0; m_se = 0; m_lock = 0; m_irq = 0; m_soft = '0;
  endtask

  task automatic model_step(input bit fire);
    int old_sh[N][3];
    int old_status, old_mask, w1c, frc, a, d, ch, off;
    bit old_se;
    old_sh = m_sh; old_se = m_se; old_status = m_status; old_mask = m_mask;
    w1c = 0; frc = 0; m_soft = '0;
    if (fire) begin
      a = int'(wr_addr); d = int'(wr_data);
      if (a < 8) begin
        case (a)
          0: if (!m_lock) m_se = d[0];
          1: if (d == 'h5A) m_lock = 1; else if (d == 'hA5) m_lock = 0;
          2: w1c = d & ALLM;
          3: if (!m_lock) m_mask = d & ALLM;
          4: if (!m_lock) frc = d & ALLM;
          default: ;
        endcase
      end else begin
        ch = (a - 8) / 8; off = a % 8;
        if (ch < N) begin
          if (off <= 2 && !m_lock) m_sh[ch][off] = d;
          else if (off == 3 && !m_lock) m_pre[ch] = d;
          else if (off == 4 && !m_lock) m_ctrl[ch] = d & 'h1F;
          else if (off == 5) m_soft[ch] = d[0];
        end
      end
    end
    m_status = ((old_status & ~w1c) | int'(ovf_evt)) & ALLM;
    m_irq = (old_status & old_mask) != 0;
    for (int c = 0; c < N; c++)
      for (int k = 0; k < 3; k++) begin
        if (!old_se || !m_se) m_act[c][k] = m_sh[c][k];
        else if (load_evt[c] || frc[c]) m_act[c][k] = old_sh[c][k];
      end
  endtask

  function automatic int model_read(input int a);
    int ch, off;
    if (a < 8) begin
      case (a)
        0: return {m_lock, m_se};
        2: return m_status;
        3: return m_mask;
        5: return N;
        default: return 0;
      endcase
    end
    ch = (a - 8) / 8; off = a % 8;
    if (ch >= N) return 0;
    if (off <= 2) return m_sh[ch][off];
    if (off == 3) return m_pre[ch];
    if (off == 4) return m_ctrl[ch];
    if (off == 6) return int'(counter_val[ch*DW +: DW]);
    return 0;
  endfunction

  task automatic check_outputs();
    logic [N*DW-1:0] ep, e1, e2, epr;
    logic [N-1:0] ece, eud, epe;
    logic [2*N-1:0] ef;
    for (int c = 0; c < N; c++) begin
      ep[c*DW +: DW]  = DW'(m_act[c][0]);
      e1[c*DW +: DW]  = DW'(m_act[c][1]);
      e2[c*DW +: DW]  = DW'(m_act[c][2]);
      epr[c*DW +: DW] = DW'(m_pre[c]);
      ece[c] = m_ctrl[c][0]; eud[c] = m_ctrl[c][1]; epe[c] = m_ctrl[c][2];
      ef[c*2 +: 2] = 2'(m_ctrl[c] >> 3);
    end
    check_eq("period", period, ep);
    check_eq("compare1", compare1, e1);
    check_eq("compare2", compare2, e2);
    check_eq("prescale", prescale, epr);
    check_eq("counter_en", 32'(counter_en), 32'(ece));
    check_eq("upnotdown", 32'(upnotdown), 32'(eud));
    check_eq("pwm_en", 32'(pwm_en), 32'(epe));
    check_eq("functions", 32'(functions), 32'(ef));
    check_eq("soft_reset", 32'(soft_reset), 32'(m_soft));
    check_eq("irq", 32'(irq), 32'(m_irq));
    check_eq($sformatf("rd_data@%0h", rd_addr), 32'(rd_data), model_read(int'(rd_addr)));
  endtask

  task automatic tick();
    bit fire;
    if (rnd_mode) begin
      load_evt    = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      ovf_evt     = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      counter_val = $urandom;
      rd_addr     = AW'($urandom_range(0, 63));
    end
    fire = 0;
    if (rst) pend = 0;
    else if (pend > 0) begin fire = (pend == 1); pend--; end
    if (rst) model_reset(); else model_step(fire);
    @(posedge clk);
    @(negedge clk);
    load_evt = '0; ovf_evt = '0;
    if (soft_reset[0]) pulse_cnt++;
    check_outputs();
  endtask

  task automatic toggle_write(input int a, input int d);
    wr_addr = AW'(a); wr_data = DW'(d); wr_toggle = ~wr_toggle; pend = 3;
  endtask

  task automatic spi_write(input int a, input int d, input int ld, input int ov);
    toggle_write(a, d);
    tick(); tick();
    if (!rnd_mode) begin load_evt = N'(ld); ovf_evt = N'(ov); end
    tick(); tick();
  endtask

  initial begin
    @(negedge clk);
    repeat (3) tick();
    rst = 1'b0;
    for (int a = 0; a < 64; a++) begin rd_addr = AW'(a); tick(); end
    rd_addr = 5; tick(); check_eq("id", 32'(rd_data), 4);
    rd_addr = 12; tick(); check_eq("ctrl0_reset", 32'(rd_data), 2);
    check_eq("irq_reset", 32'(irq), 0);

    // Unbuffered PERIOD write lands on the third edge only
    toggle_write(8 + 16, 'h40);
    tick(); tick(); check_eq("per2_early", 32'(period[23:16]), 0);
    tick(); check_eq("per2_land", 32'(period[23:16]), 'h40);
    check_eq("per_others", 32'({period[31:24], period[15:0]}), 0);
    tick();

    // Buffered COMPARE1 with a load coincident with the second write
    spi_write(0, 1, 0, 0);
    spi_write(9, 'h33, 0, 0);
    check_eq("c1_held", 32'(compare1[7:0]), 0);
    load_evt = 1; tick(); check_eq("c1_load1", 32'(compare1[7:0]), 'h33);
    spi_write(9, 'h44, 1, 0);
    check_eq("c1_coinc", 32'(compare1[7:0]), 'h33);
    load_evt = 1; tick(); check_eq("c1_load2", 32'(compare1[7:0]), 'h44);

    // Sticky status, irq, W1C vs set collision
    spi_write(3, 2, 0, 0);
    rd_addr = 2; ovf_evt = 2; tick(); tick();
    check_eq("status_set", 32'(rd_data), 2);
    check_eq("irq_set", 32'(irq), 1);
    spi_write(2, 2, 0, 2);
    check_eq("status_setwins", 32'(rd_data), 2);
    spi_write(2, 2, 0, 0);
    check_eq("status_clr", 32'(rd_data), 0);
    check_eq("irq_clr", 32'(irq), 0);

    // Lock blocks config but not COUNTER_RESET; unlock restores writes
    spi_write(8, 'h12, 0, 0);
    spi_write(1, 'h5A, 0, 0);
    spi_write(8, 'hFF, 0, 0);
    rd_addr = 8; tick(); check_eq("locked_per", 32'(rd_data), 'h12);
    toggle_write(8 + 24 + 5, 1);
    tick(); tick(); tick(); check_eq("soft3_on", 32'(soft_reset), 8);
    tick(); check_eq("soft3_off", 32'(soft_reset), 0);
    spi_write(1, 'hA5, 0, 0);
    spi_write(8, 'h77, 0, 0);
    rd_addr = 8; tick(); check_eq("unlocked_per", 32'(rd_data), 'h77);

    // Reset during sync discards the write; two spaced toggles give two writes
    toggle_write(19, 'h99);
    tick(); rst = 1'b1; tick(); tick(); rst = 1'b0;
    rd_addr = 19; repeat (4) tick();
    check_eq("rst_discard", 32'(rd_data), 0);
    pulse_cnt = 0;
    spi_write(13, 1, 0, 0);
    spi_write(13, 1, 0, 0);
    tick();
    check_eq("two_writes", pulse_cnt, 2);

    // Randomized traffic
    rnd_mode = 1;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0: spi_write(1, ($urandom_range(0, 1) != 0) ? 'h5A : 'hA5, 0, 0);
        1: spi_write(0, $urandom_range(0, 3), 0, 0);
        2: spi_write($urandom_range(2, 4), $urandom, 0, 0);
        default: spi_write($urandom_range(0, 63), $urandom, 0, 0);
      endcase
    end
    rnd_mode = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
